// File: rtl/fil_bank_loader_pkg.sv
// Shared types and default sizing for the filter-bank loader slice.
package fil_pkg;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_NUM_ROWS = 12;
  localparam int unsigned DEF_DEPTH    = 1024;
  localparam int unsigned DEF_CNT_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } fil_state_e;

endpackage

// File: rtl/fil_bank_loader_if.sv
// Write port, pass control, mapping config and per-row weight bus of the loader.
interface fil_bank_loader_if import fil_pkg::*; #(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_ROWS = DEF_NUM_ROWS,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned CNT_W    = DEF_CNT_W
) ();

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       start;
  logic [CNT_W-1:0]           cfg_p;
  logic [CNT_W-1:0]           cfg_q;
  logic [CNT_W-1:0]           cfg_r;
  logic [CNT_W-1:0]           cfg_t;
  logic [CNT_W-1:0]           cfg_R;
  logic [CNT_W-1:0]           cfg_S;
  logic                       rd_ready;
  logic [NUM_ROWS-1:0]        row_valid;
  logic [NUM_ROWS*DATA_W-1:0] row_data;
  logic                       busy;
  logic                       done;
  logic                       cfg_err;

  modport slave (
    input  wr_en, wr_addr, wr_data, start,
    input  cfg_p, cfg_q, cfg_r, cfg_t, cfg_R, cfg_S, rd_ready,
    output row_valid, row_data, busy, done, cfg_err
  );

  modport master (
    output wr_en, wr_addr, wr_data, start,
    output cfg_p, cfg_q, cfg_r, cfg_t, cfg_R, cfg_S, rd_ready,
    input  row_valid, row_data, busy, done, cfg_err
  );

endinterface

// File: rtl/fil_bank_loader_row_addr.sv
// Combinational buffer address and row-used flag for one PE-array row.
module fil_row_addr import fil_pkg::*; #(
  parameter int unsigned ROW    = 0,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned ADDR_W = $clog2(DEF_DEPTH)
) (
  input  logic [CNT_W-1:0]  i_p,
  input  logic [CNT_W-1:0]  i_q,
  input  logic [CNT_W-1:0]  i_r,
  input  logic [CNT_W-1:0]  i_t,
  input  logic [CNT_W-1:0]  i_R,
  input  logic [CNT_W-1:0]  i_S,
  input  logic [CNT_W-1:0]  i_p_idx,
  input  logic [CNT_W-1:0]  i_q_idx,
  input  logic [CNT_W-1:0]  i_s_idx,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_used
);

  // Wide enough to hold the product of all six config fields.
  localparam int unsigned FW = 6 * CNT_W + 2;

  logic [FW-1:0] w_k;
  logic [FW-1:0] w_R_div;
  logic [FW-1:0] w_r_div;
  logic [FW-1:0] w_tr;
  logic [FW-1:0] w_rr;
  logic [FW-1:0] w_ti;
  logic [FW-1:0] w_ri;
  logic [FW-1:0] w_lim;
  logic [FW-1:0] w_full;
  logic          w_unused_hi;

  assign w_k     = FW'(ROW);
  // Divisors are forced non-zero so the reset-state config never divides by 0.
  assign w_R_div = (i_R == '0) ? FW'(1) : FW'(i_R);
  assign w_r_div = (i_r == '0) ? FW'(1) : FW'(i_r);

  assign w_tr  = w_k / w_R_div;
  assign w_rr  = w_k % w_R_div;
  assign w_ti  = w_tr / w_r_div;
  assign w_ri  = w_tr % w_r_div;
  assign w_lim = FW'(i_t) * FW'(i_r) * FW'(i_R);

  assign w_full = ((((w_ti * FW'(i_p) + FW'(i_p_idx)) * FW'(i_r) + w_ri) * FW'(i_q)
                  + FW'(i_q_idx)) * FW'(i_R) + w_rr) * FW'(i_S) + FW'(i_s_idx);

  assign o_used      = (w_k < w_lim);
  assign o_addr      = o_used ? w_full[ADDR_W-1:0] : '0;
  assign w_unused_hi = ^w_full[FW-1:ADDR_W];

endmodule

// File: rtl/fil_bank_loader.sv
// Filter buffer plus load sequencer that streams mapped weights to the PE-array rows.
module fil_bank_loader import fil_pkg::*; #(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_ROWS = DEF_NUM_ROWS,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input logic              clk,
  input logic              rst,
  fil_bank_loader_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PW     = 6 * CNT_W + 2;

  logic [DATA_W-1:0]          r_mem [DEPTH];
  fil_state_e                 r_state;
  logic [CNT_W-1:0]           r_cp, r_cq, r_cr, r_ct, r_cR, r_cS;
  logic [CNT_W-1:0]           r_pi, r_qi, r_si;
  logic [NUM_ROWS-1:0]        r_row_valid;
  logic [NUM_ROWS*DATA_W-1:0] r_row_data;
  logic                       r_done;
  logic                       r_cfg_err;

  logic [PW-1:0]              w_rows;
  logic [PW-1:0]              w_ents;
  logic                       w_zero;
  logic                       w_cfg_ok;
  logic                       w_start_ok;
  logic                       w_accept;
  logic                       w_adv;
  logic                       w_p_last, w_q_last, w_s_last;
  logic [ADDR_W-1:0]          w_addr [NUM_ROWS];
  logic [NUM_ROWS-1:0]        w_used;
  logic [NUM_ROWS*DATA_W-1:0] w_beat;

  assign w_zero = (bus.cfg_p == '0) || (bus.cfg_q == '0) || (bus.cfg_r == '0) ||
                  (bus.cfg_t == '0) || (bus.cfg_R == '0) || (bus.cfg_S == '0);
  assign w_rows = PW'(bus.cfg_t) * PW'(bus.cfg_r) * PW'(bus.cfg_R);
  assign w_ents = w_rows * PW'(bus.cfg_p) * PW'(bus.cfg_q) * PW'(bus.cfg_S);
  assign w_cfg_ok = !w_zero && (w_rows <= PW'(NUM_ROWS)) && (w_ents <= PW'(DEPTH));

  assign w_start_ok = (r_state == ST_IDLE) && bus.start && w_cfg_ok;
  assign w_accept   = (|r_row_valid) && bus.rd_ready;
  // A new beat may be issued when the output stage is empty or being drained.
  assign w_adv      = (r_state == ST_LOAD) && (!(|r_row_valid) || bus.rd_ready);

  assign w_p_last = (r_pi == r_cp - CNT_W'(1));
  assign w_q_last = (r_qi == r_cq - CNT_W'(1));
  assign w_s_last = (r_si == r_cS - CNT_W'(1));

  for (genvar k = 0; k < NUM_ROWS; k++) begin : g_row
    fil_row_addr #(
      .ROW    (k),
      .CNT_W  (CNT_W),
      .ADDR_W (ADDR_W)
    ) u_row_addr (
      .i_p     (r_cp),
      .i_q     (r_cq),
      .i_r     (r_cr),
      .i_t     (r_ct),
      .i_R     (r_cR),
      .i_S     (r_cS),
      .i_p_idx (r_pi),
      .i_q_idx (r_qi),
      .i_s_idx (r_si),
      .o_addr  (w_addr[k]),
      .o_used  (w_used[k])
    );
    assign w_beat[k*DATA_W +: DATA_W] = w_used[k] ? r_mem[w_addr[k]] : '0;
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en && (r_state == ST_IDLE)) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cp        <= '0;
      r_cq        <= '0;
      r_cr        <= '0;
      r_ct        <= '0;
      r_cR        <= '0;
      r_cS        <= '0;
      r_pi        <= '0;
      r_qi        <= '0;
      r_si        <= '0;
      r_row_valid <= '0;
      r_row_data  <= '0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_cp    <= bus.cfg_p;
            r_cq    <= bus.cfg_q;
            r_cr    <= bus.cfg_r;
            r_ct    <= bus.cfg_t;
            r_cR    <= bus.cfg_R;
            r_cS    <= bus.cfg_S;
            r_pi    <= '0;
            r_qi    <= '0;
            r_si    <= '0;
            r_state <= ST_LOAD;
          end else if (bus.start) begin
            r_cfg_err <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_adv) begin
            r_row_valid <= w_used;
            r_row_data  <= w_beat;
            if (w_p_last && w_q_last && w_s_last) begin
              r_pi    <= '0;
              r_qi    <= '0;
              r_si    <= '0;
              r_state <= ST_DRAIN;
            end else if (!w_p_last) begin
              r_pi <= r_pi + CNT_W'(1);
            end else begin
              r_pi <= '0;
              if (!w_q_last) begin
                r_qi <= r_qi + CNT_W'(1);
              end else begin
                r_qi <= '0;
                r_si <= r_si + CNT_W'(1);
              end
            end
          end
        end
        ST_DRAIN: begin
          if (w_accept) begin
            r_row_valid <= '0;
            r_row_data  <= '0;
            r_done      <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.row_valid = r_row_valid;
  assign bus.row_data  = r_row_data;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = r_done;
  assign bus.cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_fil_bank_loader.sv
// Self-checking bench for fil_bank_loader: config table, corner sequences, random passes.
module tb_fil_bank_loader;
  import fil_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned NR = 12;
  localparam int unsigned DP = 1024;
  localparam int unsigned CW = 5;
  localparam int unsigned AW = $clog2(DP);

  typedef logic [NR*DW-1:0] wide_t;

  typedef struct {
    int p; int q; int r; int t; int R; int S;
    bit exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fil_bank_loader_if #(.DATA_W(DW), .NUM_ROWS(NR), .DEPTH(DP), .CNT_W(CW)) bus ();

  fil_bank_loader #(.DATA_W(DW), .NUM_ROWS(NR), .DEPTH(DP), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int unsigned mem_m [DP];
  vec_t vecs [12];

  task automatic check(input string name, input wide_t act, input wide_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_cfg(input int p, input int q, input int r, input int t, input int R, input int S);
    bus.cfg_p = CW'(p); bus.cfg_q = CW'(q); bus.cfg_r = CW'(r);
    bus.cfg_t = CW'(t); bus.cfg_R = CW'(R); bus.cfg_S = CW'(S);
  endtask

  task automatic drive_idle();
    bus.start = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_ready = 1'b1;
    set_cfg(0, 0, 0, 0, 0, 0);
  endtask

  // Reference: beat b walks p fastest, then q, then S; rows map through t, r, R.
  function automatic void expected_beat(input int p, input int q, input int r, input int t,
                                        input int R, input int S, input int b,
                                        output logic [NR-1:0] v, output wide_t d);
    int pi, qi, si, tr, rr, ti, ri, a;
    pi = b % p; qi = (b / p) % q; si = b / (p * q);
    v = '0; d = '0;
    for (int k = 0; k < NR; k++) begin
      if (k < t * r * R) begin
        tr = k / R; rr = k % R; ti = tr / r; ri = tr % r;
        a = ((((ti * p + pi) * r + ri) * q + qi) * R + rr) * S + si;
        v[k] = 1'b1;
        d[k*DW +: DW] = DW'(mem_m[a]);
      end
    end
  endfunction

  task automatic fill(input bit rnd);
    for (int i = 0; i < DP; i++) begin
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_addr = AW'(i);
      mem_m[i] = rnd ? $urandom_range(0, 65535) : i;
      bus.wr_data = DW'(mem_m[i]);
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // mode 0: always ready, 1: four-cycle stall early, 2: random ready.
  task automatic run_pass(input int p, input int q, input int r, input int t, input int R,
                          input int S, input int mode, input bit noise, input bit wr_at_start);
    int total, acc, cyc;
    bit finished, rdy, prev_stall;
    logic [NR-1:0] ev;
    wide_t ed, prev_d;
    total = p * q * S; acc = 0; cyc = 0; finished = 0; prev_stall = 0; prev_d = '0;
    @(negedge clk);
    bus.start = 1'b1; set_cfg(p, q, r, t, R, S);
    if (wr_at_start) begin
      bus.wr_en = 1'b1; bus.wr_addr = '0;
      mem_m[0] = $urandom_range(0, 65535);
      bus.wr_data = DW'(mem_m[0]);
    end
    @(negedge clk);
    bus.start = 1'b0; bus.wr_en = 1'b0;
    check("busy_after_start", wide_t'(bus.busy), wide_t'(1));
    check("no_valid_at_accept", wide_t'(bus.row_valid), '0);
    bus.rd_ready = 1'b1;
    while (!finished && cyc < 4 * total + 40) begin
      @(negedge clk);
      cyc++;
      if (acc < total) begin
        expected_beat(p, q, r, t, R, S, acc, ev, ed);
        check("beat_valid", wide_t'(bus.row_valid), wide_t'(ev));
        check("beat_data", bus.row_data, ed);
        check("busy_in_pass", wide_t'(bus.busy), wide_t'(1));
        check("no_early_done", wide_t'(bus.done), '0);
        check("no_cfg_err_in_pass", wide_t'(bus.cfg_err), '0);
        if (prev_stall) check("stall_frozen", bus.row_data, prev_d);
        case (mode)
          1:       rdy = !(cyc >= 3 && cyc < 7);
          2:       rdy = ($urandom_range(0, 3) != 0);
          default: rdy = 1'b1;
        endcase
        bus.rd_ready = rdy;
        prev_stall = !rdy;
        prev_d = bus.row_data;
        if (rdy) acc++;
        if (noise) begin
          bus.start = 1'b1; set_cfg($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                                    $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
          bus.wr_en = 1'b1; bus.wr_addr = AW'($urandom_range(0, DP - 1));
          bus.wr_data = DW'($urandom_range(0, 65535));
        end
      end else begin
        bus.start = 1'b0; bus.wr_en = 1'b0; bus.rd_ready = 1'b1;
        check("done_pulse", wide_t'(bus.done), wide_t'(1));
        check("valid_clear_at_done", wide_t'(bus.row_valid), '0);
        check("busy_low_at_done", wide_t'(bus.busy), '0);
        finished = 1;
      end
    end
    drive_idle();
    if (!finished) begin
      n_chk++; n_fail++;
      $display("FAIL pass_timeout: got %0d beats accepted, required %0d and done", acc, total);
    end
    @(negedge clk);
    check("done_one_shot", wide_t'(bus.done), '0);
  endtask

  task automatic run_reject(input int p, input int q, input int r, input int t, input int R, input int S);
    @(negedge clk);
    bus.start = 1'b1; set_cfg(p, q, r, t, R, S);
    @(negedge clk);
    bus.start = 1'b0;
    check("cfg_err_pulse", wide_t'(bus.cfg_err), wide_t'(1));
    check("reject_busy", wide_t'(bus.busy), '0);
    check("reject_valid", wide_t'(bus.row_valid), '0);
    @(negedge clk);
    check("cfg_err_one_shot", wide_t'(bus.cfg_err), '0);
    check("reject_busy_after", wide_t'(bus.busy), '0);
    check("reject_valid_after", wide_t'(bus.row_valid), '0);
  endtask

  initial begin
    logic [NR-1:0] ev;
    wide_t ed;
    int p, q, r, t, R, S;
    bit ok;

    vecs[0]  = '{2, 1, 1, 1, 3, 3, 1'b0};
    vecs[1]  = '{1, 1, 2, 2, 3, 1, 1'b0};
    vecs[2]  = '{1, 1, 1, 3, 5, 1, 1'b1};
    vecs[3]  = '{0, 1, 1, 1, 1, 1, 1'b1};
    vecs[4]  = '{1, 1, 1, 1, 1, 0, 1'b1};
    vecs[5]  = '{4, 4, 2, 2, 3, 4, 1'b0};
    vecs[6]  = '{4, 4, 2, 2, 3, 6, 1'b1};
    vecs[7]  = '{3, 2, 1, 4, 3, 5, 1'b0};
    vecs[8]  = '{1, 1, 1, 1, 12, 1, 1'b0};
    vecs[9]  = '{1, 1, 1, 1, 13, 1, 1'b1};
    vecs[10] = '{1, 1, 1, 2, 3, 1, 1'b0};
    vecs[11] = '{8, 8, 1, 1, 1, 17, 1'b1};

    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    check("rst_valid", wide_t'(bus.row_valid), '0);
    check("rst_data", bus.row_data, '0);
    check("rst_busy", wide_t'(bus.busy), '0);
    check("rst_done", wide_t'(bus.done), '0);
    check("rst_cfg_err", wide_t'(bus.cfg_err), '0);
    rst = 1'b0;

    fill(1'b0);

    // Sanity of the reference against the documented example beat.
    expected_beat(2, 1, 1, 1, 3, 3, 0, ev, ed);
    check("example_beat0_rows", ed[3*DW-1:0], wide_t'({16'd6, 16'd3, 16'd0}));

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].exp_err) run_reject(vecs[i].p, vecs[i].q, vecs[i].r, vecs[i].t, vecs[i].R, vecs[i].S);
      else run_pass(vecs[i].p, vecs[i].q, vecs[i].r, vecs[i].t, vecs[i].R, vecs[i].S, 0, 1'b0, 1'b0);
    end

    // Stall mid-pass.
    run_pass(3, 1, 1, 1, 1, 3, 1, 1'b0, 1'b0);

    // Reset while beat 3 of 9 is presented.
    @(negedge clk);
    bus.start = 1'b1; set_cfg(3, 1, 1, 1, 1, 3);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    expected_beat(3, 1, 1, 1, 1, 3, 2, ev, ed);
    check("pre_reset_beat2", bus.row_data, ed);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_valid", wide_t'(bus.row_valid), '0);
    check("async_rst_data", bus.row_data, '0);
    check("async_rst_busy", wide_t'(bus.busy), '0);
    check("async_rst_done", wide_t'(bus.done), '0);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", wide_t'(bus.done), '0);
      check("abort_idle", wide_t'(bus.busy), '0);
    end
    run_pass(3, 1, 1, 1, 1, 3, 0, 1'b0, 1'b0);

    // start/wr_en/cfg churn while busy, then read every entry back.
    run_pass(2, 1, 1, 1, 3, 3, 0, 1'b1, 1'b0);
    run_pass(8, 8, 1, 1, 1, 16, 0, 1'b0, 1'b0);

    fill(1'b1);
    for (int n = 0; n < 24; n++) begin
      p = $urandom_range(1, 4); q = $urandom_range(1, 4); r = $urandom_range(1, 4);
      t = $urandom_range(1, 4); R = $urandom_range(1, 4); S = $urandom_range(1, 4);
      if ($urandom_range(0, 7) == 0) p = 0;
      ok = (p > 0) && (t * r * R <= NR) && (t * p * q * r * R * S <= DP);
      if (ok) run_pass(p, q, r, t, R, S, 2, 1'b0, 1'b1);
      else run_reject(p, q, r, t, R, S);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
